event_tx_queue: RTL and testbench



---
 rtl/event_tx_queue.sv | 127 ++++++++++++
 tb/tb_event_tx_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/event_tx_queue.sv
// event_tx_queue: latches seven event sources, arbitrates one per cycle by
// fixed priority into the 8-bit message format, and queues the bytes in a
// first-word-fall-through FIFO drained over a valid/ready handshake.
module event_tx_queue #(
  parameter int DEPTH   = 8,
  parameter int PIECE_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       user_turn_done,
  input  logic                       draw,
  input  logic                       resign,
  input  logic                       movement_done,
  input  logic                       sending_scan_left,
  input  logic                       sending_scan_right,
  input  logic                       new_game,
  input  logic [PIECE_W-1:0]         pieces,
  input  logic [2:0]                 black_setting,
  input  logic [2:0]                 white_setting,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overrun,
  input  logic                       clear_overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Source index doubles as priority: bit 0 is the highest.
  localparam int SRC_TURN  = 0;
  localparam int SRC_DRAW  = 1;
  localparam int SRC_RESGN = 2;
  localparam int SRC_MOVE  = 3;
  localparam int SRC_SCANL = 4;
  localparam int SRC_SCANR = 5;
  localparam int SRC_NEWG  = 6;

  logic [6:0]       pulse;
  logic [6:0]       pending_q, pending_d;
  logic [6:0]       grant;
  logic [6:0]       discard;
  logic [6:0]       capture;
  logic [4:0]       scan_left_q, scan_right_q;
  logic [5:0]       settings_q;
  logic             overrun_q, overrun_d;
  logic [7:0]       push_byte;
  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem [DEPTH];

  assign pulse = {new_game, sending_scan_right, sending_scan_left,
                  movement_done, resign, draw, user_turn_done};

  // Isolate the lowest set pending bit; nothing is granted while the FIFO is full.
  assign grant = (count_q < FULL_CNT) ? (pending_q & (~pending_q + 7'd1)) : 7'd0;
  assign push  = |grant;
  assign pop   = (count_q != '0) && tx_ready;

  // A pulse on an idle or just-granted source is accepted; otherwise it is lost.
  assign capture = pulse & (~pending_q | grant);
  assign discard = pulse & pending_q & ~grant;

  // Next-state for pending bits, overrun and occupancy.
  always_comb begin
    pending_d = (pending_q & ~grant) | pulse;
    overrun_d = (overrun_q & ~clear_overrun) | (|discard);
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Encode the granted source into its message byte.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_byte = 8'h00;
    if (grant[SRC_TURN])       push_byte = 8'h00;
    else if (grant[SRC_DRAW])  push_byte = 8'h10;
    else if (grant[SRC_RESGN]) push_byte = 8'h20;
    else if (grant[SRC_MOVE])  push_byte = 8'h40;
    else if (grant[SRC_SCANL]) push_byte = {3'b101, scan_left_q};
    else if (grant[SRC_SCANR]) push_byte = {3'b100, scan_right_q};
    else if (grant[SRC_NEWG])  push_byte = {2'b11, settings_q};
  end

  // Control state: pending latches, payloads, overrun and FIFO pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      scan_left_q  <= '0;
      scan_right_q <= '0;
      settings_q   <= '0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      if (capture[SRC_SCANL]) scan_left_q  <= 5'(pieces);
      if (capture[SRC_SCANR]) scan_right_q <= 5'(pieces);
      if (capture[SRC_NEWG])  settings_q   <= {black_setting, white_setting};
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; entries are only read while the
  // count says they were written, and tx_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_byte;
  end

  assign tx_valid   = (count_q != '0);
  assign tx_data    = tx_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_event_tx_queue.sv
// Directed self-checking bench for event_tx_queue (DEPTH=8, PIECE_W=5).
module tb_event_tx_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       user_turn_done = 1'b0, draw = 1'b0, resign = 1'b0, movement_done = 1'b0;
  logic       sending_scan_left = 1'b0, sending_scan_right = 1'b0, new_game = 1'b0;
  logic [4:0] pieces = '0;
  logic [2:0] black_setting = '0, white_setting = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       clear_overrun = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  logic [7:0] exp_seq [7];

  event_tx_queue #(.DEPTH(8), .PIECE_W(5)) dut (
    .clk(clk), .reset(reset),
    .user_turn_done(user_turn_done), .draw(draw), .resign(resign),
    .movement_done(movement_done), .sending_scan_left(sending_scan_left),
    .sending_scan_right(sending_scan_right), .new_game(new_game),
    .pieces(pieces), .black_setting(black_setting), .white_setting(white_setting),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One turn_done pulse every two cycles.
  task automatic pulse_turns(input int n);
    repeat (n) begin
      user_turn_done = 1'b1; tick(); user_turn_done = 1'b0; tick();
    end
  endtask

  // Record every byte accepted by the transmitter over a fixed window.
  task automatic collect(input int cycles);
    got.delete();
    repeat (cycles) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hEE;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_seq = '{8'h00, 8'h10, 8'h20, 8'h40, 8'hB3, 8'h93, 8'hD5};

    // Reset state.
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overrun", overrun, 0);

    // Single event: two edges from pulse to output.
    draw = 1'b1; tick(); draw = 1'b0;
    check("single_pending_only", tx_valid, 0);
    tick();
    check("single_valid", tx_valid, 1);
    check("single_data", tx_data, 8'h10);
    check("single_count", fifo_count, 1);
    tx_ready = 1'b1; tick();
    check("single_popped_count", fifo_count, 0);
    check("single_popped_valid", tx_valid, 0);

    // Simultaneous events drain in priority order on consecutive cycles.
    pieces = 5'h13; black_setting = 3'd2; white_setting = 3'd5;
    {user_turn_done, draw, resign, movement_done,
     sending_scan_left, sending_scan_right, new_game} = 7'h7F;
    tick();
    {user_turn_done, draw, resign, movement_done,
     sending_scan_left, sending_scan_right, new_game} = 7'h00;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("simul_valid_%0d", i), tx_valid, 1);
      check($sformatf("simul_data_%0d", i), tx_data, exp_seq[i]);
    end
    tick();
    check("simul_empty", tx_valid, 0);

    // Full FIFO with stall.
    tx_ready = 1'b0;
    pulse_turns(8);
    check("full_count", fifo_count, 8);
    pulse_turns(1);
    check("full_hold_count", fifo_count, 8);
    check("full_no_overrun_yet", overrun, 0);
    pulse_turns(1);
    check("full_overrun_set", overrun, 1);
    tx_ready = 1'b1;
    collect(20);
    check("full_drained_bytes", got.size(), 9);
    check("full_last_byte", got_at(8), 8'h00);
    check("full_drained_count", fifo_count, 0);
    check("full_overrun_sticky", overrun, 1);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Payload captured with the pulse, not when granted.
    tx_ready = 1'b0;
    pulse_turns(8);
    pieces = 5'h0A; sending_scan_left = 1'b1; tick();
    sending_scan_left = 1'b0; pieces = 5'h1F;
    tick(); tick();
    tx_ready = 1'b1;
    collect(20);
    check("payload_bytes", got.size(), 9);
    check("payload_byte", got_at(8), 8'hAA);
    check("payload_no_overrun", overrun, 0);

    // Re-arm: pulse in the cycle the pending bit is granted.
    movement_done = 1'b1; tick(); tick(); movement_done = 1'b0;
    collect(6);
    check("rearm_bytes", got.size(), 2);
    check("rearm_first", got_at(0), 8'h40);
    check("rearm_second", got_at(1), 8'h40);
    check("rearm_overrun", overrun, 0);

    // Reset mid-operation discards queued, pending and reset-cycle events.
    tx_ready = 1'b0;
    pulse_turns(5);
    check("midrst_pre_count", fifo_count, 5);
    draw = 1'b1; resign = 1'b1; tick(); draw = 1'b0; resign = 1'b0;
    reset = 1'b1; new_game = 1'b1; tick(); reset = 1'b0; new_game = 1'b0;
    check("midrst_valid", tx_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_data", tx_data, 0);
    tx_ready = 1'b1;
    collect(6);
    check("midrst_no_bytes", got.size(), 0);
    resign = 1'b1; tick(); resign = 1'b0;
    collect(6);
    check("midrst_resign_bytes", got.size(), 1);
    check("midrst_resign_data", got_at(0), 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
